serial_rx: RTL and testbench

//  UART receiver that responds on the tenyr core operand bus (rw/addr/data), complementing the existing serial transmitter.

---
 rtl/serial_rx_pkg.sv | 42 ++++
 rtl/serial_rx_fifo.sv | 63 ++++++
 rtl/serial_rx.sv | 186 ++++++++++++++++++
 tb/tb_serial_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared constants, bus word layouts and FSM encoding for the serial_rx UART receiver.
package serial_rx_pkg;

  localparam logic [11:0] SERIAL_RX_BASE = 12'h020;

  localparam int unsigned SRX_OVR   = 15;
  localparam int unsigned SRX_FERR  = 14;
  localparam int unsigned SRX_FULL  = 13;
  localparam int unsigned SRX_EMPTY = 12;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [22:0] rsvd;
    logic        valid;
    logic [7:0]  rx_byte;
  } srx_data_t;

  typedef struct packed {
    logic [15:0] rsvd;
    logic        ovr;
    logic        ferr;
    logic        full;
    logic        empty;
    logic [3:0]  zero;
    logic [7:0]  count;
  } srx_status_t;

  // Clocks per oversample tick (16 ticks per bit), rounded down.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (16 * baud);
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Show-ahead receive FIFO; a push on a full FIFO is accepted only alongside a pop.
module serial_rx_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver on the core operand bus: DATA word at BASE, STATUS word at BASE+1.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter logic [11:0] BASE   = SERIAL_RX_BASE,
  parameter int unsigned CLK_HZ = 25_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rw,
  input  logic [BUS_W-1:0] addr,
  inout  wire  [BUS_W-1:0] data,
  input  logic             rxd,
  output logic             irq
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
  localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              rx_meta_q, rxs_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_c;

  rx_state_e         state_q, state_d;
  logic [3:0]        sc_q, sc_d;
  logic [2:0]        bi_q, bi_d;
  logic [BYTE_W-1:0] sr_q, sr_d;
  logic              push_c, ferr_set_c;

  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  logic              ovr_q, ovr_d, ferr_q, ferr_d, irq_q;
  logic              bus_ok_c, sel_data_c, sel_stat_c, rd_en_c, pop_c;
  logic              wr_stat_c, clr_ovr_c, clr_ferr_c, ovr_set_c;
  srx_data_t         data_word_c;
  srx_status_t       stat_word_c;
  logic [BUS_W-1:0]  rd_word_c;
  logic              unused_wr_bits;

  // Two-flop synchroniser; the raw line is seen nowhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Free-running 16x oversample tick.
  assign tick_c     = (tick_cnt_q == TW'(DIV - 1));
  assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      case (state_q)
        RX_IDLE:  if (!rxs_q) state_d = RX_START;
        RX_START: if (sc_q == 4'd7) state_d = rxs_q ? RX_IDLE : RX_DATA;
        RX_DATA:  if (sc_q == 4'd15 && bi_q == 3'd7) state_d = RX_STOP;
        RX_STOP:  if (sc_q == 4'd15) state_d = RX_IDLE;
        default:  state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    sc_d       = sc_q;
    bi_d       = bi_q;
    sr_d       = sr_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    if (tick_c) begin
      case (state_q)
        RX_IDLE: sc_d = '0;
        RX_START: begin
          sc_d = (sc_q == 4'd7) ? 4'd0 : sc_q + 4'd1;
          bi_d = '0;
        end
        RX_DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            sr_d = {rxs_q, sr_q[BYTE_W-1:1]};
            bi_d = bi_q + 3'd1;
          end
        end
        RX_STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            push_c     = rxs_q;
            ferr_set_c = !rxs_q;
          end
        end
        default: sc_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_q <= '0;
      bi_q <= '0;
      sr_q <= '0;
    end else begin
      sc_q <= sc_d;
      bi_q <= bi_d;
      sr_q <= sr_d;
    end
  end

  serial_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .din_i   (sr_q),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus_ok_c   = enable && (addr[BUS_W-1:12] == '0);
  assign sel_data_c = bus_ok_c && (addr[11:0] == BASE);
  assign sel_stat_c = bus_ok_c && (addr[11:0] == BASE + 12'd1);
  assign rd_en_c    = (sel_data_c || sel_stat_c) && !rw;
  assign pop_c      = sel_data_c && !rw && !fifo_empty;
  assign wr_stat_c  = sel_stat_c && rw;
  assign clr_ovr_c  = wr_stat_c && data[SRX_OVR];
  assign clr_ferr_c = wr_stat_c && data[SRX_FERR];
  assign unused_wr_bits = ^{data[BUS_W-1:16], data[13:0]};

  // A full FIFO drains one entry in the same cycle, so the byte still fits.
  assign ovr_set_c = push_c && fifo_full && !pop_c;
  assign ovr_d     = ovr_set_c  || (ovr_q  && !clr_ovr_c);
  assign ferr_d    = ferr_set_c || (ferr_q && !clr_ferr_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      irq_q  <= !fifo_empty || ovr_q || ferr_q;
    end
  end

  always_comb begin
    data_word_c         = '0;
    data_word_c.valid   = !fifo_empty;
    data_word_c.rx_byte = fifo_empty ? 8'h00 : fifo_dout;
    stat_word_c         = '0;
    stat_word_c.ovr     = ovr_q;
    stat_word_c.ferr    = ferr_q;
    stat_word_c.full    = fifo_full;
    stat_word_c.empty   = fifo_empty;
    stat_word_c.count   = 8'(fifo_count);
    rd_word_c           = sel_data_c ? BUS_W'(data_word_c) : BUS_W'(stat_word_c);
  end

  assign data = rd_en_c ? rd_word_c : {BUS_W{1'bz}};
  assign irq  = irq_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed plus randomised bench for serial_rx against a queue-based receiver model.
module tb_serial_rx;

  localparam int unsigned BIT_CLK = 64;
  localparam logic [31:0] A_DATA = 32'h0000_0020;
  localparam logic [31:0] A_STAT = 32'h0000_0021;

  logic        clk = 1'b0;
  logic        reset, enable, rw, rxd, irq;
  logic [31:0] addr;
  logic [31:0] drv_val;
  logic        drv_en;
  wire  [31:0] data;

  assign data = drv_en ? drv_val : 32'bz;

  int n_assert = 0;
  int n_fail   = 0;

  byte unsigned mq[$];
  bit           m_ovr, m_ferr;

  always #5 clk = ~clk;

  serial_rx #(
    .BASE   (12'h020),
    .CLK_HZ (16_000_000),
    .BAUD   (250_000),
    .DEPTH  (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .rw     (rw),
    .addr   (addr),
    .data   (data),
    .rxd    (rxd),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_push(input logic [7:0] b, input bit ok);
    if (!ok) m_ferr = 1'b1;
    else if (mq.size() >= 16) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction

  function automatic logic [31:0] m_status();
    int n = mq.size();
    return {16'h0, m_ovr, m_ferr, (n == 16), (n == 0), 4'h0, 8'(n)};
  endfunction

  function automatic logic [31:0] m_data_pop();
    logic [31:0] e = '0;
    if (mq.size() != 0) begin
      e = {23'h0, 1'b1, mq[0]};
      void'(mq.pop_front());
    end
    return e;
  endfunction

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; rw = 1'b0; enable = 1'b1;
    #1 v = data;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a; rw = 1'b1; drv_val = v; drv_en = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0; drv_en = 1'b0; rw = 1'b0;
    if (v[15]) m_ovr = 1'b0;
    if (v[14]) m_ferr = 1'b0;
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [31:0] v;
    bus_read(A_STAT, v);
    check(tag, v, m_status());
  endtask

  task automatic rd_data_chk(input string tag);
    logic [31:0] v;
    bus_read(A_DATA, v);
    check(tag, v, m_data_pop());
  endtask

  task automatic irq_chk(input string tag);
    repeat (2) @(posedge clk);
    #1 check(tag, 32'(irq), 32'((mq.size() != 0) || m_ovr || m_ferr));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rxd = 1'b0;
      repeat (48) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_m(input logic [7:0] b, input bit ok, input int gap);
    send_frame(b, ok, gap);
    m_push(b, ok);
  endtask

  // Issue a one-cycle DATA read in exactly the cycle the receiver pushes a byte.
  task automatic read_at_push(input logic [7:0] b, input string tag);
    logic [31:0] v, e;
    bit          seen;
    seen = 1'b0;
    v    = '0;
    fork
      send_frame(b, 1'b1, 8);
      begin
        for (int i = 0; i < 1000 && !seen; i++) begin
          @(negedge clk);
          if (dut.push_c === 1'b1) seen = 1'b1;
        end
        if (seen) begin
          addr = A_DATA; rw = 1'b0; enable = 1'b1;
          #1 v = data;
          @(posedge clk);
          #1 enable = 1'b0;
        end
      end
    join
    check({tag, "_seen"}, 32'(seen), 32'd1);
    e = m_data_pop();
    m_push(b, 1'b1);
    check(tag, v, e);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  rb;
    bit          ok;
    int          gap;

    reset = 1'b1; enable = 1'b0; rw = 1'b0; addr = '0; rxd = 1'b1;
    drv_en = 1'b0; drv_val = '0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1 check("rst_irq", 32'(irq), 32'd0);
    rd_stat_chk("rst_status");
    rd_data_chk("rst_data");

    // 1: single frame 0xA5
    send_m(8'hA5, 1'b1, 0);
    rd_stat_chk("t1_status_full1");
    irq_chk("t1_irq_set");
    bus_read(A_DATA, v);
    check("t1_data", v, 32'h1A5);
    void'(m_data_pop());
    rd_stat_chk("t1_status_after");
    irq_chk("t1_irq_clr");

    // 2: 20-clock glitch is rejected
    @(negedge clk); rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(A_STAT, v);
    check("t2_status", v, 32'h1000);

    // 3: framing error then clear
    send_m(8'h3C, 1'b0, 80);
    rd_stat_chk("t3_status_ferr");
    irq_chk("t3_irq_set");
    bus_write(A_STAT, 32'h4000);
    rd_stat_chk("t3_status_clr");
    irq_chk("t3_irq_clr");

    // 4: overflow on the 17th byte
    for (int i = 0; i < 17; i++) send_m(8'(i), 1'b1, 0);
    bus_read(A_STAT, v);
    check("t4_status_ovr", v, 32'hA010);
    check("t4_status_model", v, m_status());
    irq_chk("t4_irq");
    for (int i = 0; i < 16; i++) rd_data_chk("t4_data");
    rd_data_chk("t4_data_empty");
    bus_write(A_STAT, 32'h8000);
    rd_stat_chk("t4_status_clr");

    // Simultaneous push + pop on an empty FIFO
    read_at_push(8'h42, "t5e_read");
    rd_stat_chk("t5e_status");
    rd_data_chk("t5e_drain");

    // 5: simultaneous push + pop on a full FIFO
    for (int i = 0; i < 16; i++) send_m(8'(8'h80 + i), 1'b1, 0);
    rd_stat_chk("t5_status_full");
    read_at_push(8'h77, "t5_read");
    bus_read(A_STAT, v);
    check("t5_status_noovr", v, 32'h2010);
    for (int i = 0; i < 16; i++) rd_data_chk("t5_drain");
    rd_stat_chk("t5_status_empty");

    // 6: reset during bit 3 of a frame, with a byte already queued
    send_m(8'h11, 1'b1, 0);
    irq_chk("t6_irq_pre");
    fork
      send_frame(8'hF8, 1'b1, 20);
      begin
        repeat (1 + BIT_CLK + 3 * BIT_CLK + 32) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        check("t6_irq_rst", 32'(irq), 32'd0);
      end
    join
    bus_read(A_STAT, v);
    check("t6_status", v, 32'h1000);
    irq_chk("t6_irq_idle");
    send_m(8'h5A, 1'b1, 0);
    bus_read(A_DATA, v);
    check("t6_data", v, 32'h15A);
    void'(m_data_pop());

    // Randomised frames checked against the model
    for (int k = 0; k < 12; k++) begin
      rb  = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      gap = ok ? int'($urandom_range(0, 30)) : 40 + int'($urandom_range(0, 30));
      send_m(rb, ok, gap);
      rd_stat_chk("rnd_status");
      if ($urandom_range(0, 1) != 0) rd_data_chk("rnd_data");
    end
    irq_chk("rnd_irq");
    while (mq.size() != 0) rd_data_chk("rnd_drain");
    rd_data_chk("rnd_empty");
    bus_write(A_STAT, 32'hC000);
    rd_stat_chk("rnd_status_end");
    irq_chk("rnd_irq_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
